// File: rtl/button_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// button_conditioner_pkg
// Shared types and constants for the push-button conditioner.
//   btn_state_t          : per-channel debounce FSM state (2-bit encoding)
//   CLK_HZ               : system clock frequency, used to derive cycle counts
//   DEBOUNCE_CYCLES_DEF  : default debounce window (1 ms at CLK_HZ)
// -----------------------------------------------------------------------------
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED  = 2'd0,
    ST_ARMING    = 2'd1,
    ST_PRESSED   = 2'd2,
    ST_DISARMING = 2'd3
  } btn_state_t;

  localparam int CLK_HZ              = 16000000;
  localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 1000;

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// -----------------------------------------------------------------------------
// button_conditioner_debounce_channel
// One button channel: 2-flop synchroniser, polarity normalisation, debounce
// FSM with stable-sample counter, and registered level/press/release outputs.
// Optional macro BUTTON_REPEAT_EN adds a hold counter that re-fires btn_press
// while the button stays pressed (first after REPEAT_DELAY cycles, then every
// REPEAT_PERIOD cycles).
// Ports:
//   CLK         in  system clock
//   RST         in  synchronous active-high reset
//   btn_raw     in  raw asynchronous button pin
//   btn_level   out debounced state, 1 = pressed
//   btn_press   out one-cycle pulse on accepted press (and repeats if enabled)
//   btn_release out one-cycle pulse on accepted release
// -----------------------------------------------------------------------------
module button_conditioner_debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 8000000,
  parameter int REPEAT_PERIOD   = 2000000
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  // Reject illegal configurations at elaboration time.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20) ||
      ACTIVE_LOW < 0 || ACTIVE_LOW > 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("button_conditioner: illegal parameter value");
  end

  localparam int               CNT_W        = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             RELEASED_PIN = (ACTIVE_LOW != 0);

  logic             r_sync_p0;
  logic             r_sync_p1;
  btn_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;

  logic             w_s;
  btn_state_t       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_level_nxt;
  logic             w_press_nxt;
  logic             w_release_nxt;
  logic             w_cnt_last;
  logic             w_rep_fire;

  // Normalised sample: 1 whenever the synchronised pin differs from its
  // released level.
  assign w_s        = r_sync_p1 ^ RELEASED_PIN;
  assign w_cnt_last = (r_cnt == CNT_LAST);

`ifdef BUTTON_REPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = ($clog2(HOLD_MAX) < 1) ? 1 : $clog2(HOLD_MAX);
  localparam logic [HOLD_W-1:0] HOLD_FIRST = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] HOLD_NEXT  = HOLD_W'(REPEAT_PERIOD - 1);

  logic [HOLD_W-1:0] r_hold;
  logic              r_rep;      // first repeat already issued in this hold
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              w_rep_nxt;

  // A repeat only fires if the state is staying PRESSED on this edge.
  assign w_rep_fire = (r_state == ST_PRESSED) && w_s &&
                      (r_hold == (r_rep ? HOLD_NEXT : HOLD_FIRST));

  always_comb begin
    w_hold_nxt = '0;
    w_rep_nxt  = 1'b0;
    if (r_state == ST_PRESSED && w_s) begin
      if (w_rep_fire) begin
        w_hold_nxt = '0;
        w_rep_nxt  = 1'b1;
      end else begin
        w_hold_nxt = r_hold + HOLD_W'(1);
        w_rep_nxt  = r_rep;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hold <= '0;
      r_rep  <= 1'b0;
    end else begin
      r_hold <= w_hold_nxt;
      r_rep  <= w_rep_nxt;
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  // State register, synchroniser and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync_p0 <= RELEASED_PIN;
      r_sync_p1 <= RELEASED_PIN;
      r_state   <= ST_RELEASED;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync_p0 <= btn_raw;
      r_sync_p1 <= r_sync_p0;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  // Next-state and counter logic. Any disagreeing sample while counting
  // drops back to the stable state, so every bounce restarts from zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      ST_RELEASED: begin
        if (w_s) w_state_nxt = ST_ARMING;
      end
      ST_ARMING: begin
        if (!w_s)           w_state_nxt = ST_RELEASED;
        else if (w_cnt_last) w_state_nxt = ST_PRESSED;
        else                 w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      ST_PRESSED: begin
        if (!w_s) w_state_nxt = ST_DISARMING;
      end
      ST_DISARMING: begin
        if (w_s)             w_state_nxt = ST_PRESSED;
        else if (w_cnt_last) w_state_nxt = ST_RELEASED;
        else                 w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      default: w_state_nxt = ST_RELEASED;
    endcase
  end

  // Output logic: level tracks the pressed side of the FSM (PRESSED or
  // DISARMING); pulses mark the accepting transitions.
  always_comb begin
    w_level_nxt   = (w_state_nxt == ST_PRESSED) || (w_state_nxt == ST_DISARMING);
    w_press_nxt   = ((r_state == ST_ARMING) && w_s && w_cnt_last) || w_rep_fire;
    w_release_nxt = (r_state == ST_DISARMING) && !w_s && w_cnt_last;
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Conditions WIDTH raw, bouncy, asynchronous push-button pins into clean
// synchronous signals (bit 0 = EXEC, bit 1 = CLR in the adder build).
// Optional macro BUTTON_REPEAT_EN enables auto-repeat of btn_press while held.
// Ports:
//   CLK         in  system clock
//   RST         in  synchronous active-high reset
//   btn_raw     in  [WIDTH] raw button pins
//   btn_level   out [WIDTH] debounced state, 1 = pressed
//   btn_press   out [WIDTH] one-cycle pulse per accepted press (plus repeats)
//   btn_release out [WIDTH] one-cycle pulse per accepted release
// -----------------------------------------------------------------------------
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 8000000,
  parameter int REPEAT_PERIOD   = 2000000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    button_conditioner_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .CLK         (CLK),
      .RST         (RST),
      .btn_raw     (btn_raw[g]),
      .btn_level   (btn_level[g]),
      .btn_press   (btn_press[g]),
      .btn_release (btn_release[g])
    );
  end

endmodule
